// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 (bit-pair recoded) Booth multiplier.
// The signed WIDTH x WIDTH multiply takes WIDTH/2 iterations after a start/done handshake.
// It produces a signed 2*WIDTH-bit product.
// Optional feature macro: MUL_ZERO_SKIP_EN. When it is defined, a zero operand
// finishes one cycle after acceptance. The result is the same either way.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       m_reg;
    logic [2*WIDTH:0]       p_reg;
    logic [2*WIDTH:0]       p_next;
    logic [CW-1:0]          count_reg;
    logic [2*WIDTH-1:0]     product_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   accept;
    logic                   last_iter;

    // Booth datapath intermediates, all WIDTH+2 bits so that +/-2M cannot overflow.
    logic [WIDTH+1:0]       m_ext;
    logic [WIDTH+1:0]       m2_ext;
    logic [WIDTH+1:0]       upper_ext;
    logic [WIDTH+1:0]       addend;
    logic [WIDTH+1:0]       sum;
    logic [2*WIDTH+2:0]     widened;

`ifdef MUL_ZERO_SKIP_EN
    logic                   skip_reg;
    assign last_iter = skip_reg || (count_reg == LAST_CNT);
`else
    assign last_iter = (count_reg == LAST_CNT);
`endif

    // A request is accepted whenever the block is not iterating.
    assign accept = start && (state_reg != RUN);

    // Select the recoded Booth digit and perform one add plus arithmetic shift by two.
    always_comb begin
        m_ext     = {{2{m_reg[WIDTH-1]}}, m_reg};
        m2_ext    = {m_reg[WIDTH-1], m_reg, 1'b0};
        upper_ext = {{2{p_reg[2*WIDTH]}}, p_reg[2*WIDTH:WIDTH+1]};
        addend    = '0;
        case (p_reg[2:0])
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m2_ext;
            3'b100:         addend = -m2_ext;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum     = upper_ext + addend;
        widened = {sum, p_reg[WIDTH:0]};
        p_next  = widened[2*WIDTH+2:2];
    end

    // Next-state logic for the IDLE / RUN / DONE controller.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
        end
    end

    // Operand capture, iteration and result capture on entry to DONE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            m_reg       <= '0;
            p_reg       <= '0;
            count_reg   <= '0;
            product_reg <= '0;
`ifdef MUL_ZERO_SKIP_EN
            skip_reg    <= 1'b0;
`endif
        end else if (accept) begin
            m_reg     <= multiplicand;
            p_reg     <= {{WIDTH{1'b0}}, multiplier, 1'b0};
            count_reg <= '0;
`ifdef MUL_ZERO_SKIP_EN
            skip_reg  <= (multiplicand == '0) || (multiplier == '0);
`endif
        end else if (state_reg == RUN) begin
            p_reg     <= p_next;
            count_reg <= count_reg + 1'b1;
            if (last_iter) begin
`ifdef MUL_ZERO_SKIP_EN
                product_reg <= skip_reg ? '0 : p_next[2*WIDTH:1];
`else
                product_reg <= p_next[2*WIDTH:1];
`endif
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule
